// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by the fetch stage and the memory stage.
// One transaction is in flight at a time. Data requests win over fetch until
// STARVE_LIMIT consecutive data grants have been made with a fetch pending;
// the next grant then goes to fetch. Completion pulses and the stall requests
// for the hazard unit are combinational on the memory acknowledge.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            reset,
    // fetch port
    input  logic            ireq,
    input  logic [AW-1:0]   iaddr,
    input  logic            iflush,
    output logic [DW-1:0]   irdata,
    output logic            ivalid,
    // data port
    input  logic            dreq,
    input  logic            dwe,
    input  logic [AW-1:0]   daddr,
    input  logic [DW-1:0]   dwdata,
    input  logic [DW/8-1:0] dbe,
    output logic [DW-1:0]   drdata,
    output logic            dvalid,
    // hazard unit
    output logic            stall_if,
    output logic            stall_mem,
    // memory port
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int BW = DW / 8;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

    state_t          state, state_next;
    logic            discard, discard_next;
    logic [SW-1:0]   starve, starve_next;
    logic            mem_req_next, mem_we_next;
    logic [AW-1:0]   mem_addr_next;
    logic [DW-1:0]   mem_wdata_next;
    logic [BW-1:0]   mem_be_next;

    logic fetch_pend;
    logic starved;

    // A flushed fetch is never a candidate for a grant.
    assign fetch_pend = ireq & ~iflush;
    assign starved    = (starve == LIMIT);

    // State and request registers; everything holds unless the next-state logic changes it.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            discard   <= 1'b0;
            starve    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            state     <= state_next;
            discard   <= discard_next;
            starve    <= starve_next;
            mem_req   <= mem_req_next;
            mem_we    <= mem_we_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            mem_be    <= mem_be_next;
        end
    end

    // Arbitration in IDLE, hold-until-ack in the busy states.
    // NOTE: every signal written here gets its hold value first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        discard_next   = discard;
        starve_next    = starve;
        mem_req_next   = mem_req;
        mem_we_next    = mem_we;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        mem_be_next    = mem_be;

        case (state)
            IDLE: begin
                discard_next = 1'b0;
                if (dreq && !(fetch_pend && starved)) begin
                    state_next     = DBUSY;
                    mem_req_next   = 1'b1;
                    mem_we_next    = dwe;
                    mem_addr_next  = daddr;
                    mem_wdata_next = dwdata;
                    mem_be_next    = dwe ? dbe : '1;
                    if (!fetch_pend)
                        starve_next = '0;
                    else if (!starved)
                        starve_next = starve + 1'b1;
                end else if (fetch_pend) begin
                    state_next     = IBUSY;
                    mem_req_next   = 1'b1;
                    mem_we_next    = 1'b0;
                    mem_addr_next  = iaddr;
                    mem_wdata_next = '0;
                    mem_be_next    = '1;
                    starve_next    = '0;
                end
            end
            IBUSY: begin
                if (mem_ack) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                    discard_next = 1'b0;
                end else if (iflush) begin
                    discard_next = 1'b1;
                end
            end
            DBUSY: begin
                if (mem_ack) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                end
            end
            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

    // Completions; an ack arriving while reset is held is abandoned along with its transaction.
    assign ivalid    = ~reset & (state == IBUSY) & mem_ack & ~discard & ~iflush;
    assign dvalid    = ~reset & (state == DBUSY) & mem_ack;
    assign irdata    = mem_rdata;
    assign drdata    = mem_rdata;

    assign stall_if  = ireq & ~ivalid & ~iflush;
    assign stall_mem = dreq & ~dvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for starvation, reset mid-transaction and long latency.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq, iflush, dreq, dwe, mem_ack;
    logic [31:0] iaddr, daddr, dwdata, mem_rdata;
    logic [3:0]  dbe;
    logic [31:0] irdata, drdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        ivalid, dvalid, stall_if, stall_mem, mem_req, mem_we;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iaddr(iaddr), .iflush(iflush), .irdata(irdata), .ivalid(ivalid),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dbe(dbe),
        .drdata(drdata), .dvalid(dvalid),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        iflush;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dbe;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic        e_iv;
        logic        e_dv;
        logic        e_sif;
        logic        e_smem;
    } vec_t;

    vec_t vecs[32];

    function automatic vec_t v(
        input logic ir, input logic [31:0] ia, input logic fl,
        input logic dr, input logic we, input logic [31:0] da, input logic [31:0] dw,
        input logic [3:0] be, input logic ak, input logic [31:0] rd,
        input logic e_rq, input logic e_w, input logic [31:0] e_a, input logic [31:0] e_d,
        input logic [3:0] e_b, input logic iv, input logic dv, input logic sif, input logic smem);
        vec_t r;
        r.ireq = ir;  r.iaddr = ia;  r.iflush = fl;
        r.dreq = dr;  r.dwe = we;    r.daddr = da;  r.dwdata = dw;  r.dbe = be;
        r.ack = ak;   r.rdata = rd;
        r.e_req = e_rq; r.e_we = e_w; r.e_addr = e_a; r.e_wdata = e_d; r.e_be = e_b;
        r.e_iv = iv;  r.e_dv = dv;   r.e_sif = sif; r.e_smem = smem;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ireq = 0; iaddr = 0; iflush = 0;
        dreq = 0; dwe = 0; daddr = 0; dwdata = 0; dbe = 0;
        mem_ack = 0; mem_rdata = 0;
    endtask

    initial begin
        string exp_order;
        int    n;

        // fetch 0x100, ack two cycles after mem_req
        vecs[0]  = v(1,'h100,0, 0,0,0,0,0, 0,0,            0,0,0,0,0,          0,0,1,0);
        vecs[1]  = v(1,'h100,0, 0,0,0,0,0, 0,0,            1,0,'h100,0,'hF,    0,0,1,0);
        vecs[2]  = v(1,'h100,0, 0,0,0,0,0, 0,0,            1,0,'h100,0,'hF,    0,0,1,0);
        vecs[3]  = v(1,'h100,0, 0,0,0,0,0, 1,'hCAFEF00D,   1,0,'h100,0,'hF,    1,0,0,0);
        vecs[4]  = v(0,0,0,     0,0,0,0,0, 0,0,            0,0,0,0,0,          0,0,0,0);
        // store and fetch together: data first, fetch after return to IDLE
        vecs[5]  = v(1,'h104,0, 1,1,'h2004,'hDEADBEEF,'h3, 0,0,  0,0,0,0,0,    0,0,1,1);
        vecs[6]  = v(1,'h104,0, 1,1,'h2004,'hDEADBEEF,'h3, 0,0,  1,1,'h2004,'hDEADBEEF,'h3, 0,0,1,1);
        vecs[7]  = v(1,'h104,0, 1,1,'h2004,'hDEADBEEF,'h3, 1,0,  1,1,'h2004,'hDEADBEEF,'h3, 0,1,1,0);
        vecs[8]  = v(1,'h104,0, 0,0,0,0,0, 0,0,            0,0,0,0,0,          0,0,1,0);
        vecs[9]  = v(1,'h104,0, 0,0,0,0,0, 0,0,            1,0,'h104,0,'hF,    0,0,1,0);
        vecs[10] = v(1,'h104,0, 0,0,0,0,0, 1,'h12345678,   1,0,'h104,0,'hF,    1,0,0,0);
        vecs[11] = v(0,0,0,     0,0,0,0,0, 0,0,            0,0,0,0,0,          0,0,0,0);
        // fetch 0x200 flushed at cycle 2, acked at cycle 4, then fetch 0x300
        vecs[12] = v(1,'h200,0, 0,0,0,0,0, 0,0,            0,0,0,0,0,          0,0,1,0);
        vecs[13] = v(1,'h200,0, 0,0,0,0,0, 0,0,            1,0,'h200,0,'hF,    0,0,1,0);
        vecs[14] = v(1,'h200,1, 0,0,0,0,0, 0,0,            1,0,'h200,0,'hF,    0,0,0,0);
        vecs[15] = v(0,0,0,     0,0,0,0,0, 0,0,            1,0,'h200,0,'hF,    0,0,0,0);
        vecs[16] = v(0,0,0,     0,0,0,0,0, 1,'hBAD0BAD0,   1,0,'h200,0,'hF,    0,0,0,0);
        vecs[17] = v(1,'h300,0, 0,0,0,0,0, 0,0,            0,0,0,0,0,          0,0,1,0);
        vecs[18] = v(1,'h300,0, 0,0,0,0,0, 0,0,            1,0,'h300,0,'hF,    0,0,1,0);
        vecs[19] = v(1,'h300,0, 0,0,0,0,0, 1,'h0000300D,   1,0,'h300,0,'hF,    1,0,0,0);
        // flush blocks an IDLE grant; load waits behind a fetch; flush ignored in DBUSY
        vecs[20] = v(1,'h500,1, 0,0,0,0,0, 0,0,            0,0,0,0,0,          0,0,0,0);
        vecs[21] = v(1,'h500,0, 0,0,0,0,0, 0,0,            0,0,0,0,0,          0,0,1,0);
        vecs[22] = v(1,'h500,0, 1,0,'h600,0,0, 0,0,        1,0,'h500,0,'hF,    0,0,1,1);
        vecs[23] = v(1,'h500,0, 1,0,'h600,0,0, 1,'h11,     1,0,'h500,0,'hF,    1,0,0,1);
        vecs[24] = v(0,0,0,     1,0,'h600,0,0, 0,0,        0,0,0,0,0,          0,0,0,1);
        vecs[25] = v(0,0,1,     1,0,'h600,0,0, 0,0,        1,0,'h600,0,'hF,    0,0,0,1);
        vecs[26] = v(0,0,1,     1,0,'h600,0,0, 1,'h22,     1,0,'h600,0,'hF,    0,1,0,0);
        vecs[27] = v(0,0,0,     0,0,0,0,0, 0,0,            0,0,0,0,0,          0,0,0,0);
        // store whose request drops while busy still completes
        vecs[28] = v(0,0,0,     1,1,'h700,'h77,'hC, 0,0,   0,0,0,0,0,          0,0,0,1);
        vecs[29] = v(0,0,0,     0,0,0,0,0, 0,0,            1,1,'h700,'h77,'hC, 0,0,0,0);
        vecs[30] = v(0,0,0,     0,0,0,0,0, 1,0,            1,1,'h700,'h77,'hC, 0,1,0,0);
        vecs[31] = v(0,0,0,     0,0,0,0,0, 0,0,            0,0,0,0,0,          0,0,0,0);

        // ---------------- reset ----------------
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mem_req",  32'(mem_req), 0);
        check("rst_mem_we",   32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_be",   32'(mem_be), 0);
        check("rst_ivalid",   32'(ivalid), 0);
        check("rst_dvalid",   32'(dvalid), 0);
        tick();
        reset = 0;

        // ---------------- vector table ----------------
        for (int i = 0; i < 32; i++) begin
            ireq = vecs[i].ireq;   iaddr = vecs[i].iaddr;   iflush = vecs[i].iflush;
            dreq = vecs[i].dreq;   dwe = vecs[i].dwe;       daddr = vecs[i].daddr;
            dwdata = vecs[i].dwdata; dbe = vecs[i].dbe;
            mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("v%0d_mem_req", i),   32'(mem_req),   32'(vecs[i].e_req));
            check($sformatf("v%0d_ivalid", i),    32'(ivalid),    32'(vecs[i].e_iv));
            check($sformatf("v%0d_dvalid", i),    32'(dvalid),    32'(vecs[i].e_dv));
            check($sformatf("v%0d_stall_if", i),  32'(stall_if),  32'(vecs[i].e_sif));
            check($sformatf("v%0d_stall_mem", i), 32'(stall_mem), 32'(vecs[i].e_smem));
            if (vecs[i].e_req) begin
                check($sformatf("v%0d_mem_we", i),   32'(mem_we), 32'(vecs[i].e_we));
                check($sformatf("v%0d_mem_addr", i), mem_addr,    vecs[i].e_addr);
                check($sformatf("v%0d_mem_be", i),   32'(mem_be), 32'(vecs[i].e_be));
                if (vecs[i].e_we)
                    check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            end
            if (vecs[i].e_iv) check($sformatf("v%0d_irdata", i), irdata, vecs[i].rdata);
            if (vecs[i].e_dv) check($sformatf("v%0d_drdata", i), drdata, vecs[i].rdata);
            tick();
        end

        // ---------------- starvation: both held, zero-wait memory ----------------
        exp_order = "DDDIDDDI";
        n = 0;
        ireq = 1; iaddr = 'h400; dreq = 1; dwe = 0; daddr = 'h3000; dbe = 0;
        mem_ack = mem_req; mem_rdata = 'h5555;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(negedge clk);
            if (ivalid || dvalid) begin
                check($sformatf("grant_order_%0d", n), 32'(dvalid ? 8'h44 : 8'h49),
                      32'(exp_order[n]));
                n++;
            end
            tick();
            mem_ack = mem_req;
        end
        check("grant_count", n, 8);
        idle_inputs();
        tick();

        // ---------------- reset during DBUSY, then stray ack ----------------
        dreq = 1; dwe = 0; daddr = 'h80;
        tick();
        @(negedge clk);
        check("rstx_busy_req", 32'(mem_req), 1);
        tick();
        reset = 1; mem_ack = 1; mem_rdata = 'h99;
        @(negedge clk);
        check("rstx_dvalid_in_reset", 32'(dvalid), 0);
        tick();
        reset = 0; dreq = 0; mem_ack = 1;
        @(negedge clk);
        check("rstx_stray_dvalid", 32'(dvalid), 0);
        check("rstx_stray_req",    32'(mem_req), 0);
        tick();
        mem_ack = 0;
        @(negedge clk);
        check("rstx_idle_req", 32'(mem_req), 0);
        check("rstx_idle_dvalid", 32'(dvalid), 0);
        tick();

        // ---------------- load 0x40, ack five cycles after mem_req ----------------
        dreq = 1; dwe = 0; daddr = 'h40; dbe = 0; mem_ack = 0;
        @(negedge clk);
        check("lat_c0_req",   32'(mem_req), 0);
        check("lat_c0_stall", 32'(stall_mem), 1);
        for (int c = 1; c <= 5; c++) begin
            tick();
            @(negedge clk);
            check($sformatf("lat_c%0d_req", c),   32'(mem_req), 1);
            check($sformatf("lat_c%0d_addr", c),  mem_addr, 'h40);
            check($sformatf("lat_c%0d_stall", c), 32'(stall_mem), 1);
            check($sformatf("lat_c%0d_dvalid", c), 32'(dvalid), 0);
        end
        tick();
        mem_ack = 1; mem_rdata = 'hA5A55A5A;
        @(negedge clk);
        check("lat_ack_dvalid", 32'(dvalid), 1);
        check("lat_ack_drdata", drdata, 'hA5A55A5A);
        check("lat_ack_addr",   mem_addr, 'h40);
        check("lat_ack_be",     32'(mem_be), 'hF);
        check("lat_ack_stall",  32'(stall_mem), 0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("lat_done_req", 32'(mem_req), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the pipelined core.
- Sequences one outstanding memory transaction at a time and returns read data to the winning requester.
- Generates the fetch and memory-stage stall requests that the hazard logic ORs into its stall/flush network.
- Data has priority over fetch, with a starvation limit that guarantees fetch progress.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- STARVE_LIMIT, 3, consecutive data grants with ireq pending after which the next grant goes to fetch (≥1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ireq  in  1  fetch read request; held with iaddr stable until ivalid or iflush.
- iaddr  in  AW  fetch address.
- iflush  in  1  fetch squash (branch taken); discards any pending or in-flight fetch result.
- irdata  out  DW  instruction word; valid only while ivalid=1.
- ivalid  out  1  fetch completion pulse, one cycle.
- dreq  in  1  data request; held with fields stable until dvalid.
- dwe  in  1  1=store, 0=load.
- daddr  in  AW  data address.
- dwdata  in  DW  store data.
- dbe  in  DW/8  store byte enables.
- drdata  out  DW  load data; valid only while dvalid=1.
- dvalid  out  1  data completion pulse, one cycle, for both loads and stores.
- stall_if  out  1  ireq & ~ivalid & ~iflush.
- stall_mem  out  1  dreq & ~dvalid.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  write enable, registered at grant.
- mem_addr  out  AW  address, registered at grant.
- mem_wdata  out  DW  write data, registered at grant.
- mem_be  out  DW/8  byte enables; all ones for fetch and loads.
- mem_ack  in  1  memory completion, one cycle; mem_rdata valid with it.
- mem_rdata  in  DW  memory read data.

Behaviour:
- FSM states: IDLE, IBUSY, DBUSY. Registers: state, discard bit, starve counter (width clog2(STARVE_LIMIT+1)), and the mem_* request registers.
- Reset: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, discard=0, starve=0.
  - ivalid and dvalid are 0 in the reset cycle and in the cycle after it.
  - Reset mid-transaction abandons the transaction; a later stray mem_ack while in IDLE is ignored.
- IDLE arbitration, evaluated each cycle:
  - dreq only → DBUSY.
  - ireq & ~iflush only → IBUSY.
  - Both → DBUSY, unless starve==STARVE_LIMIT, in which case IBUSY.
  - On the grant edge, mem_req<=1 and mem_we/addr/wdata/be are loaded from the winning requester.
- Starve counter:
  - On a data grant with ireq & ~iflush high: increment, saturating at STARVE_LIMIT.
  - On a data grant with no fetch request pending: clear.
  - On any fetch grant: clear.
- Busy states: mem_req and all mem_* fields are held until mem_ack. On mem_ack: mem_req<=0, state<=IDLE.
  - The earliest regrant is therefore the cycle after ack. Minimum occupancy is 2 cycles per access.
- Completion, combinational:
  - ivalid = (state==IBUSY) & mem_ack & ~discard & ~iflush.
  - dvalid = (state==DBUSY) & mem_ack.
  - irdata and drdata both pass mem_rdata through.
- Latency: request seen in IDLE at cycle 0 → mem_req high at cycle 1 → valid in the cycle mem_ack arrives (≥ cycle 1).
- Flush:
  - iflush in IBUSY sets discard; the transaction still runs to mem_ack, then ivalid is suppressed and discard clears on the return to IDLE.
  - iflush coinciding with the ack also suppresses ivalid.
  - iflush in IDLE blocks a fetch grant that cycle.
  - iflush has no effect on DBUSY.
- Simultaneous events:
  - A new dreq during IBUSY waits; stall_mem stays high.
  - ireq and dreq both dropping while busy does not abort the transaction; the result is still pulsed.

Test Plan:
- Reset, then ireq=1, iaddr=0x100, with memory acking 2 cycles after mem_req → mem_req high cycle 1 with mem_addr=0x100, mem_be=0xF; ivalid=1 cycle 3 with irdata=mem_rdata; stall_if=1 cycles 0–2.
- dreq=1, dwe=1, daddr=0x2004, dwdata=0xDEADBEEF, dbe=0x3, with ireq=1 in the same cycle → data granted first (mem_we=1, mem_be=0x3); dvalid on ack; fetch granted the cycle after the return to IDLE.
- STARVE_LIMIT=3, ireq and dreq held continuously, 0-wait memory → grant order D,D,D,I,D,D,D,I; starve returns to 0 after each I.
- Fetch 0x200 in IBUSY, iflush pulsed at cycle 2, ack at cycle 4 → ivalid stays 0 at cycle 4; state IDLE at cycle 5; the next fetch (0x300) is then granted normally.
- Reset asserted during DBUSY, then a stray mem_ack one cycle after reset deasserts → mem_req=0, no dvalid, state stays IDLE.
- Load at 0x40 with 5-cycle memory latency → stall_mem=1 until dvalid, mem_addr stable for the whole transaction, drdata=mem_rdata in the ack cycle.
